// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 bus monitor: opcode masks, DDRAM layout
// constants, FSM state type and the address-counter stepping rule.
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h04;
    localparam logic [7:0] CMD_DISPCTL = 8'h08;
    localparam logic [7:0] CMD_SHIFT   = 8'h10;
    localparam logic [7:0] CMD_FUNCSET = 8'h20;
    localparam logic [7:0] CMD_SETCG   = 8'h40;
    localparam logic [7:0] CMD_SETDD   = 8'h80;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE_LEN   = 7'd40;
    localparam logic [6:0] LINE0_LAST = LINE0_BASE + LINE_LEN - 7'd1;
    localparam logic [6:0] LINE1_LAST = LINE1_BASE + LINE_LEN - 7'd1;

    localparam int CELLS   = 32;
    localparam int CELL_AW = 5;

    typedef enum logic {
        IDLE,
        CLEAR
    } lcd_mon_state_t;

    // Next DDRAM address after a data write. Holes between the two lines and
    // above line 1 are legal AC values; any step out of them lands on the
    // start of the following line regardless of direction.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] nxt;
        if (ac > LINE1_LAST) begin
            nxt = LINE0_BASE;
        end else if (ac > LINE0_LAST && ac < LINE1_BASE) begin
            nxt = LINE1_BASE;
        end else if (inc) begin
            if (ac == LINE0_LAST)      nxt = LINE1_BASE;
            else if (ac == LINE1_LAST) nxt = LINE0_BASE;
            else                       nxt = ac + 7'd1;
        end else begin
            if (ac == LINE0_BASE)      nxt = LINE1_LAST;
            else if (ac == LINE1_BASE) nxt = LINE0_LAST;
            else                       nxt = ac - 7'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_ddram_shadow.sv
// 32x8 shadow of the visible screen: one write port, one registered read port.
// A read of the cell being written in the same cycle returns the old byte.
module lcd_ddram_shadow
    import lcd_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               we_i,
    input  logic [CELL_AW-1:0] waddr_i,
    input  logic [7:0]         wdata_i,
    input  logic               rd_en_i,
    input  logic [CELL_AW-1:0] raddr_i,
    output logic [7:0]         rdata_o
);

    logic [7:0] mem_q [CELLS];
    logic [7:0] rdata_q;

    // Storage array; contents are defined by the sweep, so no reset here.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read, held at zero until the array has been swept once.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= rd_en_i ? mem_q[raddr_i] : 8'h00;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_hd44780_monitor.sv
// Receiving side of an 8-bit HD44780 bus: synchronizes the async pins, detects
// the E falling edge, decodes commands/data and keeps a 2x16 screen shadow.
// Visible columns are limited to 16 per line by the 32-cell shadow.
module lcd_hd44780_monitor
    import lcd_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         COLS        = 16,
    parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       lcd_rs,
    input  logic       lcd_e,
    input  logic [7:0] lcd_d,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       display_on,
    output logic [6:0] cursor_addr,
    output logic       busy,
    output logic       update,
    output logic       overflow
);

    localparam int         LAST   = SYNC_STAGES - 1;
    localparam logic [6:0] COLS_W = 7'(COLS);

    logic [SYNC_STAGES-1:0] rs_sync_q;
    logic [SYNC_STAGES-1:0] e_sync_q;
    logic [7:0]             d_sync_q [SYNC_STAGES];
    logic                   e_last_q;
    logic                   strobe;
    logic                   stb_q, stb_rs_q;
    logic [7:0]             stb_dat_q;

    lcd_mon_state_t state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [6:0]     ac_q, ac_d;
    logic           id_q, id_d;
    logic           cg_q, cg_d;
    logic           disp_q, disp_d;
    logic           pend_v_q, pend_v_d;
    logic           pend_rs_q, pend_rs_d;
    logic [7:0]     pend_dat_q, pend_dat_d;
    logic           ovf_q, ovf_d;
    logic           boot_q, boot_d;
    logic           swept_q, swept_d;
    logic           upd_q, upd_d;

    logic           we;
    logic [4:0]     waddr;
    logic [7:0]     wdata;
    logic           exec_v, exec_rs;
    logic [7:0]     exec_dat;
    logic           ac_visible;

    assign strobe     = e_last_q & ~e_sync_q[LAST];
    assign ac_visible = (ac_q < LINE0_BASE + COLS_W) ||
                        (ac_q >= LINE1_BASE && ac_q < LINE1_BASE + COLS_W);

    // Input synchronizers and strobe capture; rs/d are taken from the same
    // synchronized cycle in which E is seen falling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs_sync_q <= '0;
            e_sync_q  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) d_sync_q[i] <= 8'h00;
            e_last_q  <= 1'b0;
            stb_q     <= 1'b0;
            stb_rs_q  <= 1'b0;
            stb_dat_q <= 8'h00;
        end else begin
            rs_sync_q   <= {rs_sync_q[SYNC_STAGES-2:0], lcd_rs};
            e_sync_q    <= {e_sync_q[SYNC_STAGES-2:0], lcd_e};
            d_sync_q[0] <= lcd_d;
            for (int i = 1; i < SYNC_STAGES; i++) d_sync_q[i] <= d_sync_q[i-1];
            e_last_q  <= e_sync_q[LAST];
            stb_q     <= strobe;
            stb_rs_q  <= rs_sync_q[LAST];
            stb_dat_q <= d_sync_q[LAST];
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            ac_q       <= LINE0_BASE;
            id_q       <= 1'b1;
            cg_q       <= 1'b0;
            disp_q     <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_rs_q  <= 1'b0;
            pend_dat_q <= 8'h00;
            ovf_q      <= 1'b0;
            boot_q     <= 1'b1;
            swept_q    <= 1'b0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ac_q       <= ac_d;
            id_q       <= id_d;
            cg_q       <= cg_d;
            disp_q     <= disp_d;
            pend_v_q   <= pend_v_d;
            pend_rs_q  <= pend_rs_d;
            pend_dat_q <= pend_dat_d;
            ovf_q      <= ovf_d;
            boot_q     <= boot_d;
            swept_q    <= swept_d;
            upd_q      <= upd_d;
        end
    end

    // Sweep/idle sequencing, pending slot, and decode of the executed strobe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ac_d       = ac_q;
        id_d       = id_q;
        cg_d       = cg_q;
        disp_d     = disp_q;
        pend_v_d   = pend_v_q;
        pend_rs_d  = pend_rs_q;
        pend_dat_d = pend_dat_q;
        ovf_d      = ovf_q;
        boot_d     = boot_q;
        swept_d    = swept_q;
        upd_d      = 1'b0;
        we         = 1'b0;
        waddr      = cnt_q;
        wdata      = CLEAR_CHAR;
        exec_v     = 1'b0;
        exec_rs    = 1'b0;
        exec_dat   = 8'h00;

        case (state_q)
            CLEAR: begin
                we    = 1'b1;
                cnt_d = cnt_q + 5'd1;
                if (stb_q) begin
                    if (pend_v_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        pend_v_d   = 1'b1;
                        pend_rs_d  = stb_rs_q;
                        pend_dat_d = stb_dat_q;
                    end
                end
                if (cnt_q == 5'(CELLS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                    ac_d    = LINE0_BASE;
                    id_d    = 1'b1;
                    upd_d   = 1'b1;
                    swept_d = 1'b1;
                end
            end
            default: begin
                if (boot_q) begin
                    boot_d  = 1'b0;
                    state_d = CLEAR;
                    cnt_d   = 5'd0;
                    if (stb_q) begin
                        pend_v_d   = 1'b1;
                        pend_rs_d  = stb_rs_q;
                        pend_dat_d = stb_dat_q;
                    end
                end else if (pend_v_q) begin
                    exec_v     = 1'b1;
                    exec_rs    = pend_rs_q;
                    exec_dat   = pend_dat_q;
                    pend_v_d   = stb_q;
                    pend_rs_d  = stb_rs_q;
                    pend_dat_d = stb_dat_q;
                end else if (stb_q) begin
                    exec_v   = 1'b1;
                    exec_rs  = stb_rs_q;
                    exec_dat = stb_dat_q;
                end
            end
        endcase

        if (exec_v) begin
            if (!exec_rs) begin
                if (|(exec_dat & CMD_SETDD)) begin
                    ac_d = exec_dat[6:0];
                    cg_d = 1'b0;
                end else if (|(exec_dat & CMD_SETCG)) begin
                    cg_d = 1'b1;
                end else if (|(exec_dat & (CMD_FUNCSET | CMD_SHIFT))) begin
                    ac_d = ac_q;
                end else if (|(exec_dat & CMD_DISPCTL)) begin
                    disp_d = exec_dat[2];
                    upd_d  = (exec_dat[2] != disp_q);
                end else if (|(exec_dat & CMD_ENTRY)) begin
                    id_d = exec_dat[1];
                end else if (|(exec_dat & CMD_HOME)) begin
                    ac_d = LINE0_BASE;
                end else if (|(exec_dat & CMD_CLEAR)) begin
                    state_d = CLEAR;
                    cnt_d   = 5'd0;
                end
            end else if (!cg_q) begin
                if (ac_visible) begin
                    we    = 1'b1;
                    waddr = {ac_q[6], ac_q[3:0]};
                    wdata = exec_dat;
                    upd_d = 1'b1;
                end
                ac_d = ac_step(ac_q, id_q);
            end
        end
    end

    lcd_ddram_shadow u_shadow (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .rd_en_i   (swept_q),
        .raddr_i   (rd_addr),
        .rdata_o   (rd_data)
    );

    assign display_on  = disp_q;
    assign cursor_addr = ac_q;
    assign busy        = (state_q == CLEAR);
    assign update      = upd_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_lcd_hd44780_monitor.sv
// Self-checking bench for lcd_hd44780_monitor: drives HD44780 bus writes and
// compares the screen shadow and status outputs with a behavioural LCD model.
module tb_lcd_hd44780_monitor;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       lcd_rs, lcd_e;
    logic [7:0] lcd_d;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       display_on, busy, update, overflow;
    logic [6:0] cursor_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_count = 0;

    logic [7:0] m_cell [32];
    int         m_ac;
    bit         m_id, m_cg, m_disp;
    int         m_upd = 0;

    lcd_hd44780_monitor dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .lcd_rs      (lcd_rs),
        .lcd_e       (lcd_e),
        .lcd_d       (lcd_d),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .display_on  (display_on),
        .cursor_addr (cursor_addr),
        .busy        (busy),
        .update      (update),
        .overflow    (overflow)
    );

    always #10 clk = ~clk;

    // Counts every cycle in which update is high.
    always @(posedge clk) begin
        if (update === 1'b1) upd_count++;
    end

    // ---------------- behavioural LCD model ----------------
    function automatic bit m_visible(input int a);
        return (a < 16) || (a >= 64 && a < 80);
    endfunction

    function automatic int m_cell_of(input int a);
        return (a < 64) ? a : a - 64 + 16;
    endfunction

    function automatic int m_next(input int a, input bit inc);
        int line, off;
        if (a >= 40 && a < 64) return 64;
        if (a >= 104) return 0;
        line = a / 64;
        off  = a % 64;
        if (inc) begin
            if (off == 39) return (line == 0) ? 64 : 0;
            return a + 1;
        end
        if (off == 0) return (line == 0) ? 103 : 39;
        return a - 1;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
        m_ac = 0;
        m_id = 1'b1;
        m_upd++;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
        m_ac   = 0;
        m_id   = 1'b1;
        m_cg   = 1'b0;
        m_disp = 1'b0;
    endfunction

    function automatic void m_apply(input bit rs, input logic [7:0] d);
        int v;
        bit on;
        v = int'(d);
        if (!rs) begin
            if (v >= 128) begin
                m_ac = v - 128;
                m_cg = 1'b0;
            end else if (v >= 64) begin
                m_cg = 1'b1;
            end else if (v >= 16) begin
                m_cg = m_cg;
            end else if (v >= 8) begin
                on = ((v / 4) % 2) == 1;
                if (on != m_disp) m_upd++;
                m_disp = on;
            end else if (v >= 4) begin
                m_id = ((v / 2) % 2) == 1;
            end else if (v >= 2) begin
                m_ac = 0;
            end else if (v == 1) begin
                m_clear();
            end
        end else if (!m_cg) begin
            if (m_visible(m_ac)) begin
                m_cell[m_cell_of(m_ac)] = d;
                m_upd++;
            end
            m_ac = m_next(m_ac, m_id);
        end
    endfunction

    // ---------------- bus drivers ----------------
    task automatic lcd_write(input bit rs, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs;
        lcd_d  = d;
        @(negedge clk);
        lcd_e = 1'b1;
        repeat (3) @(negedge clk);
        lcd_e = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic send(input bit rs, input logic [7:0] d);
        lcd_write(rs, d);
        m_apply(rs, d);
    endtask

    task automatic read_cell(input int i, output logic [7:0] v);
        @(negedge clk);
        rd_addr = 5'(i);
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic wait_idle(output bit ok);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = (busy === 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic measure_sweep(output int hi, output int ud);
        int u0, t;
        hi = 0;
        t  = 0;
        u0 = upd_count;
        @(negedge clk);
        reset_n = 1'b1;
        while (t < 200) begin
            @(negedge clk);
            t++;
            if (busy === 1'b1) hi++;
            else if (hi > 0) break;
        end
        repeat (3) @(negedge clk);
        ud = upd_count - u0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] obs [6];
        string      nm [6];
        logic [7:0] v;
        int hi, ud;
        reset_n = 1'b0;
        lcd_rs  = 1'b0;
        lcd_e   = 1'b0;
        lcd_d   = 8'h00;
        rd_addr = 5'd0;
        repeat (3) @(negedge clk);
        obs = '{rd_data, {7'd0, display_on}, {1'b0, cursor_addr},
                {7'd0, busy}, {7'd0, update}, {7'd0, overflow}};
        nm  = '{"rst_rd_data", "rst_display_on", "rst_cursor", "rst_busy", "rst_update", "rst_overflow"};
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obs[i] !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL %s: got %h expected 00", nm[i], obs[i]);
            end
        end
        measure_sweep(hi, ud);
        m_reset();
        n_checks++;
        if (hi !== 32) begin
            n_fail++;
            $display("[TB] FAIL boot_busy_cycles: got %0d expected 32", hi);
        end
        n_checks++;
        if (ud !== 1) begin
            n_fail++;
            $display("[TB] FAIL boot_update_pulses: got %0d expected 1", ud);
        end
        for (int i = 0; i < 32; i++) begin
            read_cell(i, v);
            n_checks++;
            if (v !== 8'h20) begin
                n_fail++;
                $display("[TB] FAIL boot_cell%0d: got %h expected 20", i, v);
            end
        end
        n_checks++;
        if (cursor_addr !== 7'h00) begin
            n_fail++;
            $display("[TB] FAIL boot_cursor: got %h expected 00", cursor_addr);
        end
    endtask

    task automatic test_data_write();
        logic [7:0] v;
        int u0, m0;
        u0 = upd_count;
        m0 = m_upd;
        send(1'b0, 8'h80);
        send(1'b1, 8'h41);
        send(1'b1, 8'h42);
        read_cell(0, v);
        n_checks++;
        if (v !== 8'h41) begin
            n_fail++;
            $display("[TB] FAIL data_cell0: got %h expected 41", v);
        end
        read_cell(1, v);
        n_checks++;
        if (v !== 8'h42) begin
            n_fail++;
            $display("[TB] FAIL data_cell1: got %h expected 42", v);
        end
        n_checks++;
        if (cursor_addr !== 7'h02) begin
            n_fail++;
            $display("[TB] FAIL data_cursor: got %h expected 02", cursor_addr);
        end
        n_checks++;
        if ((upd_count - u0) !== 2 || (m_upd - m0) !== 2) begin
            n_fail++;
            $display("[TB] FAIL data_updates: got %0d expected 2", upd_count - u0);
        end
    endtask

    task automatic test_line1_overrun();
        logic [7:0] v;
        send(1'b0, 8'hC0);
        for (int i = 0; i < 17; i++) send(1'b1, 8'($urandom_range(33, 126)));
        for (int i = 16; i < 32; i++) begin
            read_cell(i, v);
            n_checks++;
            if (v !== m_cell[i]) begin
                n_fail++;
                $display("[TB] FAIL line1_cell%0d: got %h expected %h", i, v, m_cell[i]);
            end
        end
        n_checks++;
        if (cursor_addr !== 7'h51) begin
            n_fail++;
            $display("[TB] FAIL line1_cursor: got %h expected 51", cursor_addr);
        end
    endtask

    task automatic test_ac_wrap();
        logic [7:0] v;
        send(1'b0, 8'h04);
        send(1'b0, 8'h80);
        send(1'b1, 8'h58);
        read_cell(0, v);
        n_checks++;
        if (v !== 8'h58) begin
            n_fail++;
            $display("[TB] FAIL wrap_cell0: got %h expected 58", v);
        end
        n_checks++;
        if (cursor_addr !== 7'h67) begin
            n_fail++;
            $display("[TB] FAIL wrap_dec_00: got %h expected 67", cursor_addr);
        end
        send(1'b0, 8'hC0);
        send(1'b1, 8'h44);
        n_checks++;
        if (cursor_addr !== 7'h27) begin
            n_fail++;
            $display("[TB] FAIL wrap_dec_40: got %h expected 27", cursor_addr);
        end
        send(1'b0, 8'h06);
        send(1'b0, 8'hA7);
        send(1'b1, 8'h59);
        n_checks++;
        if (cursor_addr !== 7'h40) begin
            n_fail++;
            $display("[TB] FAIL wrap_inc_27: got %h expected 40", cursor_addr);
        end
        send(1'b1, 8'h5B);
        read_cell(16, v);
        n_checks++;
        if (v !== 8'h5B) begin
            n_fail++;
            $display("[TB] FAIL wrap_cell16: got %h expected 5b", v);
        end
        send(1'b0, 8'hBA);
        send(1'b1, 8'h21);
        n_checks++;
        if (cursor_addr !== 7'h40) begin
            n_fail++;
            $display("[TB] FAIL wrap_hole: got %h expected 40", cursor_addr);
        end
        send(1'b0, 8'hF0);
        send(1'b1, 8'h22);
        n_checks++;
        if (cursor_addr !== 7'h00) begin
            n_fail++;
            $display("[TB] FAIL wrap_top: got %h expected 00", cursor_addr);
        end
    endtask

    task automatic test_clear_pending();
        logic [7:0] v;
        bit ok;
        int u0, m0;
        send(1'b0, 8'h06);
        send(1'b0, 8'h80);
        for (int i = 0; i < 16; i++) send(1'b1, 8'($urandom_range(33, 126)));
        send(1'b0, 8'hC0);
        for (int i = 0; i < 16; i++) send(1'b1, 8'($urandom_range(33, 126)));
        u0 = upd_count;
        m0 = m_upd;
        lcd_write(1'b0, 8'h01);
        m_clear();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL clear_busy: got %b expected 1", busy);
        end
        lcd_write(1'b1, 8'h5A);
        m_apply(1'b1, 8'h5A);
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL clear_timeout: busy got %b expected 0", busy);
        end
        for (int i = 0; i < 32; i++) begin
            read_cell(i, v);
            n_checks++;
            if (v !== m_cell[i]) begin
                n_fail++;
                $display("[TB] FAIL clear_cell%0d: got %h expected %h", i, v, m_cell[i]);
            end
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_no_overflow: got %b expected 0", overflow);
        end
        n_checks++;
        if (cursor_addr !== 7'(m_ac)) begin
            n_fail++;
            $display("[TB] FAIL clear_cursor: got %h expected %h", cursor_addr, 7'(m_ac));
        end
        n_checks++;
        if ((upd_count - u0) !== (m_upd - m0)) begin
            n_fail++;
            $display("[TB] FAIL clear_updates: got %0d expected %0d", upd_count - u0, m_upd - m0);
        end
        lcd_write(1'b0, 8'h01);
        m_clear();
        lcd_write(1'b1, 8'h31);
        m_apply(1'b1, 8'h31);
        lcd_write(1'b1, 8'h32);
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL clear2_timeout: busy got %b expected 0", busy);
        end
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL clear_overflow: got %b expected 1", overflow);
        end
        for (int i = 0; i < 2; i++) begin
            read_cell(i, v);
            n_checks++;
            if (v !== m_cell[i]) begin
                n_fail++;
                $display("[TB] FAIL clear2_cell%0d: got %h expected %h", i, v, m_cell[i]);
            end
        end
    endtask

    task automatic test_cgram_display();
        logic [7:0] v;
        int u0;
        u0 = upd_count;
        send(1'b0, 8'h40);
        send(1'b1, 8'h55);
        read_cell(m_cell_of(m_ac), v);
        n_checks++;
        if (v !== m_cell[m_cell_of(m_ac)] || v === 8'h55) begin
            n_fail++;
            $display("[TB] FAIL cgram_cell: got %h expected %h", v, m_cell[m_cell_of(m_ac)]);
        end
        n_checks++;
        if (cursor_addr !== 7'(m_ac)) begin
            n_fail++;
            $display("[TB] FAIL cgram_cursor: got %h expected %h", cursor_addr, 7'(m_ac));
        end
        n_checks++;
        if ((upd_count - u0) !== 0) begin
            n_fail++;
            $display("[TB] FAIL cgram_no_update: got %0d expected 0", upd_count - u0);
        end
        u0 = upd_count;
        send(1'b0, 8'h0C);
        n_checks++;
        if (display_on !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL disp_on: got %b expected 1", display_on);
        end
        send(1'b0, 8'h0E);
        n_checks++;
        if ((upd_count - u0) !== 1) begin
            n_fail++;
            $display("[TB] FAIL disp_update: got %0d expected 1", upd_count - u0);
        end
        send(1'b0, 8'h80);
    endtask

    task automatic test_random();
        logic [7:0] d, v;
        bit rs;
        int sel, u0, m0;
        u0 = upd_count;
        m0 = m_upd;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            rs  = 1'b0;
            case (sel)
                0, 1, 2, 3, 4: begin rs = 1'b1; d = 8'($urandom_range(0, 255)); end
                5: d = 8'(128 + $urandom_range(0, 127));
                6: d = 8'(4 + $urandom_range(0, 3));
                7: d = 8'(8 + $urandom_range(0, 7));
                8: d = 8'(2 + $urandom_range(0, 1));
                default: begin
                    case ($urandom_range(0, 3))
                        0: d = 8'(64 + $urandom_range(0, 63));
                        1: d = 8'(16 + $urandom_range(0, 15));
                        2: d = 8'(32 + $urandom_range(0, 31));
                        default: d = 8'h00;
                    endcase
                end
            endcase
            send(rs, d);
            n_checks++;
            if (cursor_addr !== 7'(m_ac)) begin
                n_fail++;
                $display("[TB] FAIL rand_cursor op%0d rs=%b d=%h: got %h expected %h", n, rs, d, cursor_addr, 7'(m_ac));
            end
            n_checks++;
            if (display_on !== m_disp) begin
                n_fail++;
                $display("[TB] FAIL rand_display op%0d: got %b expected %b", n, display_on, m_disp);
            end
        end
        for (int i = 0; i < 32; i++) begin
            read_cell(i, v);
            n_checks++;
            if (v !== m_cell[i]) begin
                n_fail++;
                $display("[TB] FAIL rand_cell%0d: got %h expected %h", i, v, m_cell[i]);
            end
        end
        n_checks++;
        if ((upd_count - u0) !== (m_upd - m0)) begin
            n_fail++;
            $display("[TB] FAIL rand_updates: got %0d expected %0d", upd_count - u0, m_upd - m0);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [7:0] obs [6];
        string      nm [6];
        logic [7:0] v;
        int hi, ud;
        send(1'b0, 8'h0C);
        lcd_write(1'b0, 8'h01);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        obs = '{rd_data, {7'd0, display_on}, {1'b0, cursor_addr},
                {7'd0, busy}, {7'd0, update}, {7'd0, overflow}};
        nm  = '{"mid_rd_data", "mid_display_on", "mid_cursor", "mid_busy", "mid_update", "mid_overflow"};
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obs[i] !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL %s: got %h expected 00", nm[i], obs[i]);
            end
        end
        repeat (2) @(negedge clk);
        measure_sweep(hi, ud);
        m_reset();
        n_checks++;
        if (hi !== 32) begin
            n_fail++;
            $display("[TB] FAIL mid_busy_cycles: got %0d expected 32", hi);
        end
        n_checks++;
        if (ud !== 1) begin
            n_fail++;
            $display("[TB] FAIL mid_update_pulses: got %0d expected 1", ud);
        end
        for (int i = 0; i < 32; i++) begin
            read_cell(i, v);
            n_checks++;
            if (v !== 8'h20) begin
                n_fail++;
                $display("[TB] FAIL mid_cell%0d: got %h expected 20", i, v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_line1_overrun();
        test_ac_wrap();
        test_clear_pending();
        test_cgram_display();
        test_random();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
